// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1-to-4 valid/ready demultiplexer.
// One input stream is routed per beat (in_sel) into one of four independent
// 2-entry channel buffers, so a stalled consumer only blocks its own channel.
// Each channel also keeps a saturating count of beats delivered downstream.
module demux_1to4_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   output logic [4*WIDTH-1:0]   out_data,
   output logic [4*CNT_W-1:0]   beat_cnt
);

   // Channel occupancy doubles as the channel state.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0] occ [4];
   logic [3:0] push;
   logic [3:0] pop;

   // Delivered-beat counter step that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Input backpressure comes only from the selected channel's registered
   // occupancy, never from out_ready, so there is no combinational path
   // from consumers back to the producer.
   always_comb begin
      in_ready = (occ[in_sel] != ST_FULL);
   end

   for (genvar ch = 0; ch < 4; ch++) begin : g_ch
      logic [1:0]       cnt;
      logic             wp;
      logic             rp;
      logic [WIDTH-1:0] mem [2];
      logic [CNT_W-1:0] bcnt;

      assign occ[ch]                       = cnt;
      assign push[ch]                      = in_valid && in_ready && (in_sel == 2'(ch));
      assign pop[ch]                       = out_valid[ch] && out_ready[ch];
      assign out_valid[ch]                 = (cnt != ST_EMPTY);
      assign out_data[ch*WIDTH +: WIDTH]   = mem[rp];
      assign beat_cnt[ch*CNT_W +: CNT_W]   = bcnt;

      // Per-channel FIFO storage, pointers, occupancy and delivered-beat count.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt    <= ST_EMPTY;
            wp     <= 1'b0;
            rp     <= 1'b0;
            bcnt   <= '0;
            mem[0] <= '0;
            mem[1] <= '0;
         end else begin
            if (push[ch]) begin
               mem[wp] <= in_data;
               wp      <= ~wp;
            end
            if (pop[ch]) begin
               rp   <= ~rp;
               bcnt <= sat_inc(bcnt);
            end
            // Push+pop together only happens in ST_ONE and leaves it unchanged.
            case ({push[ch], pop[ch]})
               2'b10:   cnt <= (cnt == ST_EMPTY) ? ST_ONE : ST_FULL;
               2'b01:   cnt <= (cnt == ST_FULL)  ? ST_ONE : ST_EMPTY;
               default: cnt <= cnt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Testbench for demux_1to4_stream: directed scenarios plus random traffic,
// checked by a queue-based scoreboard. A second instance with a 4-bit
// counter covers beat counter saturation on the same traffic.
module tb_demux_1to4_stream;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic [3:0]       out_ready;

   logic             in_ready,  in_ready_s;
   logic [3:0]       out_valid, out_valid_s;
   logic [4*WIDTH-1:0] out_data, out_data_s;
   logic [4*16-1:0]  beat_cnt;
   logic [4*4-1:0]   beat_cnt_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   demux_1to4_stream #(.WIDTH(WIDTH), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .beat_cnt(beat_cnt)
   );

   demux_1to4_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .beat_cnt(beat_cnt_s)
   );

   // Reference model: per-channel queue of accepted-but-undelivered beats,
   // plus a count of delivered beats per channel.
   logic [WIDTH-1:0] q [4][$];
   int               pops [4];
   bit               armed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: compare DUT outputs against the model between edges, then
   // advance the model by the handshakes the next rising edge will perform.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            q[c].delete();
            pops[c] = 0;
         end
         armed = 1;
      end else if (armed) begin
         int  s;
         bit  exp_rdy;
         bit  ev [4];
         s       = int'(in_sel);
         exp_rdy = (q[s].size() < 2);
         chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
         for (int c = 0; c < 4; c++) begin
            ev[c] = (q[c].size() != 0);
            chk($sformatf("out_valid[%0d]", c), {31'b0, out_valid[c]}, {31'b0, ev[c]});
            chk($sformatf("sat_out_valid[%0d]", c), {31'b0, out_valid_s[c]}, {31'b0, ev[c]});
            if (ev[c])
               chk($sformatf("out_data[%0d]", c), {24'b0, out_data[c*WIDTH +: WIDTH]},
                   {24'b0, q[c][0]});
            chk($sformatf("beat_cnt[%0d]", c), {16'b0, beat_cnt[c*16 +: 16]},
                (pops[c] > 65535) ? 32'd65535 : pops[c]);
            chk($sformatf("sat_beat_cnt[%0d]", c), {28'b0, beat_cnt_s[c*4 +: 4]},
                (pops[c] > 15) ? 32'd15 : pops[c]);
         end
         for (int c = 0; c < 4; c++) begin
            if (ev[c] && out_ready[c]) begin
               void'(q[c].pop_front());
               pops[c]++;
            end
         end
         if (in_valid && exp_rdy) q[s].push_back(in_data);
      end
   end

   // Present one beat (or idle) for exactly one cycle.
   task automatic drive1(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   // Hold a beat until it is accepted, within a bounded number of cycles.
   task automatic send(input logic [1:0] s, input logic [WIDTH-1:0] d);
      bit acc;
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
      acc      = 0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected accept of %0h on ch%0d", d, s);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive1(1'b0, in_sel, in_data);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset.
      idle(10);

      // One beat to each channel on consecutive cycles.
      drive1(1'b1, 2'd0, 8'h11);
      drive1(1'b1, 2'd1, 8'h22);
      drive1(1'b1, 2'd2, 8'h33);
      drive1(1'b1, 2'd3, 8'h44);
      idle(4);

      // Fill ch2 while its consumer stalls, bypass to ch1, then release.
      out_ready = 4'b1011;
      send(2'd2, 8'hA0);
      send(2'd2, 8'hA1);
      drive1(1'b1, 2'd2, 8'hA2);
      drive1(1'b1, 2'd1, 8'hB0);
      out_ready = 4'b1111;
      send(2'd2, 8'hA2);
      idle(4);

      // Full-rate streaming into ch3.
      for (int k = 0; k < 16; k++) drive1(1'b1, 2'd3, 8'(k));
      idle(4);

      // Reset with ch0 FULL and ch1 ONE; buffered beats must vanish.
      out_ready = 4'b0000;
      drive1(1'b1, 2'd0, 8'hC0);
      drive1(1'b1, 2'd0, 8'hC1);
      drive1(1'b1, 2'd1, 8'hD0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 4'b1111;
      idle(5);

      // 17 beats through ch0 to saturate the 4-bit counter instance.
      for (int k = 0; k < 17; k++) drive1(1'b1, 2'd0, 8'(8'h60 + k));
      idle(4);

      // Random traffic and random backpressure.
      for (int k = 0; k < 400; k++) begin
         out_ready = 4'($urandom_range(0, 15));
         drive1(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
      end

      // Drain.
      out_ready = 4'b1111;
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "timeout");
   end

endmodule
